mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Sequencer and owner of the HI/LO register pair for the multiply/divide unit.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage.
//  - Runs a fixed multi-cycle latency and commits results to HI/LO.
//  - Drives busy to the hazard unit, and hi/lo to the MFHI/MFLO select path.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk         in   1   sole clock, rising edge
//  reset       in   1   asynchronous, active-low (0 = reset)
//  md_op       in   4   `MD_NONE/`MD_MULT/`MD_MULTU/`MD_DIV/`MD_DIVU/`MD_MTHI/`MD_MTLO
//  exc_cancel  in   1   exception/flush this cycle; blocks acceptance of md_op
//  rs          in   32  operand A (dividend / MTxx source)
//  rt          in   32  operand B (divisor)
//  busy        out  1   operation in flight; HI/LO not yet valid
//  hi          out  32  architectural HI
//  lo          out  32  architectural LO
// BEHAVIOUR
//  - Reset (async, reset==0):
//    - hi=0, lo=0, busy=0, counter=0, pending regs=0, state=IDLE.
//    - Takes effect mid-operation: the in-flight result is dropped.
//  - Accept condition: md_op!=NONE && !exc_cancel && state==IDLE.
//    - md_op arriving while busy is ignored (the hazard unit stalls E, so this must not occur).
//  - FSM IDLE->BUSY on accepted mult/div:
//    - At the accept edge, compute the full result from rs/rt into pend_hi/pend_lo.
//    - Load the counter with MULT_CYCLES or DIV_CYCLES.
//  - BUSY: the counter decrements each edge.
//    - The edge at which the counter==1: hi<=pend_hi, lo<=pend_lo, busy->0, state->IDLE.
//    - If accepted at edge k: busy=1 in cycles k+1..k+N; new hi/lo are visible from cycle k+N+1.
//  - busy is registered, with no combinational path from md_op.
//    - The hazard unit ORs in the E-stage start itself.
//  - MTHI/MTLO (IDLE only): hi<=rs or lo<=rs at the accept edge. Zero latency; busy stays 0.
//  - Arithmetic:
//    - MULT: signed 32x32->64; MULTU: unsigned. {hi,lo}=product.
//    - DIV/DIVU: lo=quotient, hi=remainder (signed: truncate toward zero, remainder takes the sign of the dividend).
//    - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0.
//    - Divisor==0: the op is accepted and runs full DIV_CYCLES; hi/lo are unchanged at commit.
//  - exc_cancel=1 together with a valid md_op: no state change.
//    - exc_cancel has no effect on an op already in BUSY; it completes, matching MIPS semantics.
//  - hi/lo change only at a commit edge, an MTxx edge, or reset.
// STRUCTURE
//  - macrodefine.v: MD_* opcode constants, state encodings, and MULT/DIV cycle defaults.
//  - Arithmetic is pure combinational inside this module (*, /, % on $signed/unsigned operands).
//    - Sub-module md_alu: rs, rt, op -> 64-bit {hi_res,lo_res} plus a div0 flag.
//  - mdu_ctrl holds the FSM, counter, pending regs and HI/LO.
// TESTING
//  1. Reset: reset=0 mid-DIV (counter=4) -> busy=0, hi=lo=0 immediately. After release, an MTLO 5 gives lo=5.
//  2. MULT rs=0xFFFFFFFF rt=2 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     Same operands with MULTU -> hi=1, lo=0xFFFFFFFE.
//  3. DIV rs=-7 rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4. DIVU rs=9 rt=0, with hi=0x11 and lo=0x22 before -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
//  5. MTHI rs=0xABCD with exc_cancel=1 -> hi unchanged, busy=0.
//     Next cycle with exc_cancel=0 -> hi=0xABCD after one edge.
//  6. MULT accepted, then MTLO 7 presented during busy -> ignored.
//     At commit, lo = product low word, not 7.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - opcodes, FSM states, latency defaults and ALU result type for the MDU
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } alu_res_t;

    function automatic logic is_mult(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage request and HI/LO/busy result bundle for the MDU
interface mdu_ctrl_if;
    logic [3:0]  md_op;
    logic        exc_cancel;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op, exc_cancel, rs, rt,
        input  busy, hi, lo
    );

    modport slave (
        input  md_op, exc_cancel, rs, rt,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl_alu.sv
// rtl/mdu_ctrl_alu.sv - combinational multiply/divide producing {hi,lo} and a divide-by-zero flag
module mdu_ctrl_alu
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output alu_res_t    res_o
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div0;
    logic               ovf;
    logic        [31:0] den_s;
    logic        [31:0] den_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    assign div0 = (rt_i == 32'd0);
    assign ovf  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

    // Dividing by 1 instead yields the required 0x80000000 rem 0 for the overflow
    // case, and keeps the zero-divisor path free of X (its result is discarded).
    assign den_s = (div0 || ovf) ? 32'd1 : rt_i;
    assign den_u = div0 ? 32'd1 : rt_i;

    assign quo_s = $signed(rs_i) / $signed(den_s);
    assign rem_s = $signed(rs_i) % $signed(den_s);
    assign quo_u = rs_i / den_u;
    assign rem_u = rs_i % den_u;

    always_comb begin
        res_o = '0;
        case (op_i)
            MD_MULT:  {res_o.hi, res_o.lo} = prod_s;
            MD_MULTU: {res_o.hi, res_o.lo} = prod_u;
            MD_DIV: begin
                res_o.hi   = rem_s;
                res_o.lo   = quo_s;
                res_o.div0 = div0;
            end
            MD_DIVU: begin
                res_o.hi   = rem_u;
                res_o.lo   = quo_u;
                res_o.div0 = div0;
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencer: fixed-latency mult/div, MTHI/MTLO, owner of HI/LO
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mdu_ctrl_if.slave    bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_div0_q, pend_div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    alu_res_t alu_res;
    logic     accept;

    mdu_ctrl_alu u_alu (
        .op_i  (bus.md_op),
        .rs_i  (bus.rs),
        .rt_i  (bus.rt),
        .res_o (alu_res)
    );

    assign accept = (bus.md_op != MD_NONE) && !bus.exc_cancel && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mult(bus.md_op) || is_div(bus.md_op)) begin
                        state_d     = ST_BUSY;
                        cnt_d       = is_mult(bus.md_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        pend_hi_d   = alu_res.hi;
                        pend_lo_d   = alu_res.lo;
                        pend_div0_d = alu_res.div0;
                    end else if (bus.md_op == MD_MTHI) begin
                        hi_d = bus.rs;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_d = bus.rs;
                    end
                end
            end
            ST_BUSY: begin
                // Requests arriving here are ignored; the hazard unit holds E stalled.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    if (!pend_div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_div0_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.busy = (state_q == ST_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and randomized checks of mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int latency(input logic [3:0] op);
        if (op == MD_MULT || op == MD_MULTU) return MC;
        if (op == MD_DIV || op == MD_DIVU) return DC;
        return 0;
    endfunction

    // Reference: signed divide done on magnitudes, then signs applied by the architectural rule.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qa, ra, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MD_DIV: if (b != 0) begin
                qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                ra = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
                q  = ((sa < 0) != (sb < 0)) ? -qa : qa;
                r  = (sa < 0) ? -ra : ra;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MD_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Presents one request for one edge, then follows the expected busy window.
    // With intrude set, an MTLO 7 is presented during the busy window.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cancel, input logic intrude);
        int n;
        logic [31:0] old_hi, old_lo;
        bus.md_op      = op;
        bus.rs         = a;
        bus.rt         = b;
        bus.exc_cancel = cancel;
        @(posedge clk);
        #1;
        bus.md_op      = MD_NONE;
        bus.exc_cancel = 1'b0;
        n      = cancel ? 0 : latency(op);
        old_hi = m_hi;
        old_lo = m_lo;
        if (!cancel) model_apply(op, a, b);
        for (int i = 0; i < n; i++) begin
            check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            check({tag, ".hold_hi"}, bus.hi, old_hi);
            check({tag, ".hold_lo"}, bus.lo, old_lo);
            if (intrude && i == 1) begin
                bus.md_op = MD_MTLO;
                bus.rs    = 32'd7;
            end else begin
                bus.md_op = MD_NONE;
            end
            @(posedge clk);
            #1;
        end
        bus.md_op = MD_NONE;
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".hi"}, bus.hi, m_hi);
        check({tag, ".lo"}, bus.lo, m_lo);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        cancel;

        reset          = 1'b0;
        bus.md_op      = MD_NONE;
        bus.exc_cancel = 1'b0;
        bus.rs         = '0;
        bus.rt         = '0;
        m_hi           = '0;
        m_lo           = '0;
        #12;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.hi", bus.hi, 32'd0);
        check("reset.lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("mult.exp_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult.exp_lo", bus.lo, 32'hFFFF_FFFE);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("multu.exp_hi", bus.hi, 32'd1);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div.exp_lo", bus.lo, 32'hFFFF_FFFD);
        check("div.exp_hi", bus.hi, 32'hFFFF_FFFF);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf.exp_lo", bus.lo, 32'h8000_0000);
        check("div_ovf.exp_hi", bus.hi, 32'd0);
        run_op("mthi", MD_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
        run_op("mtlo", MD_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
        run_op("divu0", MD_DIVU, 32'd9, 32'd0, 1'b0, 1'b0);
        check("divu0.exp_hi", bus.hi, 32'h11);
        check("divu0.exp_lo", bus.lo, 32'h22);
        run_op("mthi_cancel", MD_MTHI, 32'hABCD, 32'd0, 1'b1, 1'b0);
        check("mthi_cancel.exp_hi", bus.hi, 32'h11);
        run_op("mthi_go", MD_MTHI, 32'hABCD, 32'd0, 1'b0, 1'b0);
        check("mthi_go.exp_hi", bus.hi, 32'hABCD);
        run_op("mult_cancel", MD_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
        run_op("mult_intr", MD_MULT, 32'd6, 32'd7, 1'b0, 1'b1);
        check("mult_intr.exp_lo", bus.lo, 32'd42);

        for (int k = 0; k < 60; k++) begin
            op     = 4'($urandom_range(1, 6));
            a      = $urandom;
            b      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            cancel = ($urandom_range(0, 4) == 0);
            run_op($sformatf("rnd%0d", k), op, a, b, cancel, $urandom_range(0, 3) == 0);
        end

        run_op("pre_rst_hi", MD_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0);
        run_op("pre_rst_lo", MD_MTLO, 32'h5678, 32'd0, 1'b0, 1'b0);
        bus.md_op = MD_DIV;
        bus.rs    = 32'd100;
        bus.rt    = 32'd7;
        @(posedge clk);
        #1;
        bus.md_op = MD_NONE;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid.busy_before", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid.busy", 32'(bus.busy), 32'd0);
        check("rst_mid.hi", bus.hi, 32'd0);
        check("rst_mid.lo", bus.lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("post_rst_mtlo", MD_MTLO, 32'd5, 32'd0, 1'b0, 1'b0);
        check("post_rst.exp_lo", bus.lo, 32'd5);
        check("post_rst.exp_hi", bus.hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
